// File: rtl/snow64_long_mul_u16_by_u8_radix_8.sv
// Iterative radix-8 multiply-accumulate: out_data = in_a*in_b (+ in_c), 6 iterations per result.
// Optional addend controlled by SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN; when undefined in_c is ignored.
module snow64_long_mul_u16_by_u8_radix_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_c,
  output logic [23:0] out_data,
  output logic        out_valid,
  output logic        out_can_accept_cmd
);

  typedef enum logic {
    StIdle,
    StWorking
  } state_t;

  state_t      state;
  logic [17:0] captured_a;
  logic [10:0] mult_arr [8];
  logic [2:0]  i;
  logic [23:0] acc;

  logic [2:0]  digit;
  logic [23:0] acc_shift_add;
  logic [23:0] acc_final;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  logic [7:0]  captured_c;
`else
  logic        unused_in_c;
  assign unused_in_c = ^in_c;
`endif

  // Radix-8 digit of the multiplicand for the current iteration, MSB digit first.
  always_comb begin
    digit = '0;
    case (i)
      3'd0:    digit = captured_a[2:0];
      3'd1:    digit = captured_a[5:3];
      3'd2:    digit = captured_a[8:6];
      3'd3:    digit = captured_a[11:9];
      3'd4:    digit = captured_a[14:12];
      3'd5:    digit = captured_a[17:15];
      default: digit = '0;
    endcase
  end

  always_comb begin
    acc_shift_add = {acc[20:0], 3'b000} + {13'd0, mult_arr[digit]};
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    acc_final     = acc_shift_add + {16'd0, captured_c};
`else
    acc_final     = acc_shift_add;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= StIdle;
      captured_a         <= '0;
      for (int unsigned k = 0; k < 8; k++) mult_arr[k] <= '0;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
      captured_c         <= '0;
`endif
      i                  <= '0;
      acc                <= '0;
      out_data           <= '0;
      out_valid          <= 1'b0;
      out_can_accept_cmd <= 1'b1;
    end else begin
      case (state)
        StIdle: begin
          if (in_start) begin
            captured_a <= {2'b00, in_a};
            for (int unsigned k = 0; k < 8; k++) mult_arr[k] <= 11'(in_b) * 11'(k);
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
            captured_c <= in_c;
`endif
            i                  <= 3'd5;
            acc                <= '0;
            out_valid          <= 1'b0;
            out_can_accept_cmd <= 1'b0;
            state              <= StWorking;
          end
        end
        StWorking: begin
          if (i == 3'd0) begin
            acc                <= acc_final;
            out_data           <= acc_final;
            out_valid          <= 1'b1;
            out_can_accept_cmd <= 1'b1;
            state              <= StIdle;
          end else begin
            acc <= acc_shift_add;
            i   <= i - 3'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_long_mul_u16_by_u8_radix_8.sv
// Self-checking bench for snow64_long_mul_u16_by_u8_radix_8 (table vectors, corner sequences, divider round-trip).
// Expected values follow SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN when it is defined for the build.
module tb_snow64_long_mul_u16_by_u8_radix_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [15:0] in_a = '0;
  logic [7:0]  in_b = '0;
  logic [7:0]  in_c = '0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_can_accept_cmd;

  snow64_long_mul_u16_by_u8_radix_8 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_start           (in_start),
    .in_a               (in_a),
    .in_b               (in_b),
    .in_c               (in_c),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_can_accept_cmd (out_can_accept_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [23:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] sb [$];
  logic [23:0] last_result = '0;
  vec_t        vecs [8];

  function automatic logic [23:0] model(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c);
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    return 24'(a) * 24'(b) + 24'(c);
`else
    return 24'(a) * 24'(b) + 24'(0 * c);
`endif
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  // One full operation; optionally pulses a bogus start at i=3 that must be ignored.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [23:0] exp, input bit glitch, input string name);
    int cycles;
    logic [23:0] e;
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_start = 1'b0;
    chk({name, "_valid_after_capture"}, 24'(out_valid), 24'd0);
    chk({name, "_cmd_after_capture"}, 24'(out_can_accept_cmd), 24'd0);
    chk({name, "_data_held"}, out_data, last_result);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (glitch && cycles == 2) begin
        in_a = ~a; in_b = ~b; in_c = ~c; in_start = 1'b1;
      end else begin
        in_start = 1'b0;
      end
    end
    chk({name, "_latency"}, 24'(cycles), 24'd6);
    chk({name, "_cmd_done"}, 24'(out_can_accept_cmd), 24'd1);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, out_data, e);
    end
    last_result = exp;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] dvd, q;
    logic [7:0]  dvs, r;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    vecs[0] = '{16'h1234, 8'h56, 8'h12, 24'h061D8A};
    vecs[1] = '{16'hFFFF, 8'hFF, 8'hFF, 24'hFF0000};
    vecs[2] = '{16'h0ABC, 8'h00, 8'h7F, 24'h00007F};
    vecs[3] = '{16'h0000, 8'hFF, 8'h55, 24'h000055};
    vecs[4] = '{16'h0007, 8'h09, 8'h01, 24'h000040};
    vecs[5] = '{16'h0001, 8'h01, 8'h00, 24'h000001};
    vecs[6] = '{16'h0100, 8'h10, 8'h0F, 24'h00100F};
    vecs[7] = '{16'h8001, 8'h80, 8'h80, 24'h400100};
`else
    vecs[0] = '{16'h1234, 8'h56, 8'h12, 24'h061D78};
    vecs[1] = '{16'hFFFF, 8'hFF, 8'hFF, 24'hFEFF01};
    vecs[2] = '{16'h0ABC, 8'h00, 8'h7F, 24'h000000};
    vecs[3] = '{16'h0000, 8'hFF, 8'h55, 24'h000000};
    vecs[4] = '{16'h0007, 8'h09, 8'h01, 24'h00003F};
    vecs[5] = '{16'h0001, 8'h01, 8'h00, 24'h000001};
    vecs[6] = '{16'h0100, 8'h10, 8'h0F, 24'h001000};
    vecs[7] = '{16'h8001, 8'h80, 8'h80, 24'h400080};
`endif

    // Reset with random inputs toggling.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_a = 16'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_start = 1'($urandom);
    end
    #1;
    chk("reset_data", out_data, 24'd0);
    chk("reset_valid", 24'(out_valid), 24'd0);
    chk("reset_cmd", 24'(out_can_accept_cmd), 24'd1);
    @(negedge clk);
    in_start = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[k]) do_op(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].exp, 1'b0, $sformatf("vec%0d", k));

    // Start pulse mid-operation is ignored; the next op starts while out_valid is high.
    do_op(16'h1234, 8'h56, 8'h12, model(16'h1234, 8'h56, 8'h12), 1'b1, "glitch");
    do_op(16'h0F0F, 8'hA5, 8'h3C, model(16'h0F0F, 8'hA5, 8'h3C), 1'b0, "after_glitch");

    // Asynchronous reset at i=2.
    @(negedge clk);
    in_a = 16'h1234; in_b = 8'h56; in_c = 8'h12; in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_data", out_data, 24'd0);
    chk("midreset_valid", 24'(out_valid), 24'd0);
    chk("midreset_cmd", 24'(out_can_accept_cmd), 24'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_result = '0;
    do_op(16'h0007, 8'h09, 8'h01, model(16'h0007, 8'h09, 8'h01), 1'b0, "post_reset");

    // Divider round-trip: quotient*divisor + remainder reconstructs the dividend.
    for (int k = 0; k < 1000; k++) begin
      dvd = 16'($urandom);
      dvs = 8'($urandom_range(1, 255));
      q   = dvd / 16'(dvs);
      r   = 8'(dvd % 16'(dvs));
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
      do_op(q, dvs, r, {8'd0, dvd}, 1'b0, "roundtrip");
`else
      do_op(q, dvs, r, 24'(dvd) - 24'(r), 1'b0, "roundtrip");
`endif
    end

    chk("scoreboard_empty", 24'(sb.size()), 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snow64_long_mul_u16_by_u8_radix_8.md
# snow64_long_mul_u16_by_u8_radix_8

Iterative radix-8 unsigned multiply-accumulate computing `a*b + c` for a 16-bit `a`, 8-bit `b` and 8-bit `c`, producing a 24-bit result. It is the inverse companion of the u16-by-u8 radix-8 long divider. Feeding it the divider's quotient, divisor and remainder reconstructs the dividend. It uses the same start / valid / can-accept-cmd command handshake and sits beside the divider in the snow64 arithmetic unit.

## Interface
Parameters: none. All widths are fixed.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `in_start`  in  1  Command strobe; sampled only when `out_can_accept_cmd`=1.
- `in_a`  in  16  Multiplicand; the divider's quotient.
- `in_b`  in  8  Multiplier; the divider's divisor.
- `in_c`  in  8  Addend; the divider's remainder.
- `out_data`  out  24  Result.
- `out_valid`  out  1  `out_data` holds a completed result.
- `out_can_accept_cmd`  out  1  Block is idle and will accept `in_start`.

## Operation
States are StIdle and StWorking. Reset state is StIdle.

StIdle:
- On `in_start`=1, capture the operands:
  - `captured_a` = {2'b00, `in_a`}, 18 bits.
  - `captured_c` = `in_c`.
  - Multiple table `mult_arr[k]` = `in_b`*k for k=0..7; each entry is 11 bits.
- Set `i`=5, clear the accumulator.
- Drive `out_valid`=0 and `out_can_accept_cmd`=0.
- Go to StWorking.

StWorking, iteration `i` (5 down to 0):
- Select digit d = `captured_a`[3i+2:3i].
- Update: `acc` = (`acc` << 3) + `mult_arr[d]`. The accumulator is 24 bits; no overflow is possible.
- When `i`=0:
  - Add the addend: `acc` += `captured_c`.
  - Load `out_data` with the result.
  - Set `out_valid`=1 and `out_can_accept_cmd`=1.
  - Go to StIdle.
- Otherwise `i` decrements.

Result holding:
- `out_data` and `out_valid` hold until the next accepted `in_start`.
- That start clears `out_valid` on its capture edge. `out_data` stays unchanged until the next completion.

Boundary behaviour:
- `in_b`=0: table is all zeros; result = `in_c`, or 0 when the addend is compiled out.
- `in_a`=0: result = `in_c`.
- Maximum operands: 0xFFFF*0xFF + 0xFF = 0xFF0000, which fits in 24 bits.
- `in_start` during StWorking is ignored. No queueing; operands are not re-captured.
- `rst_n` low at any time, including mid-operation, immediately forces:
  - StIdle, `i`=0, `acc`=0;
  - `out_data`=0, `out_valid`=0, `out_can_accept_cmd`=1.
  
  The partial result is discarded. Operation resumes on the first `clk` edge after deassertion.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_can_accept_cmd`=1.
- Capture edge E0 samples `in_start`=1. From the cycle after E0, `out_can_accept_cmd`=0.
- Edges E1..E6 perform iterations `i`=5..0.
- After E6, `out_valid`=1 and `out_can_accept_cmd`=1. Latency is 6 cycles from capture.
- Back-to-back operation: `in_start` held high in the cycle after completion is accepted at the next edge. Throughput is one result per 7 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN`
  - Defined: the `i`=0 iteration adds `captured_c`, giving `out_data` = `a*b + c`.
  - Undefined: `in_c` stays in the port list but is ignored; it is neither captured nor added, giving `out_data` = `a*b`. Timing is identical either way.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `out_data`=0, `out_valid`=0, `out_can_accept_cmd`=1.
- Nominal: `a`=0x1234, `b`=0x56, `c`=0x12, start -> `out_valid` rises 6 cycles after capture.
  - With the macro: `out_data`=0x061D8A.
  - Without the macro: `out_data`=0x061D78.
- Extremes:
  - `a`=0xFFFF, `b`=0xFF, `c`=0xFF -> 0xFF0000 (0xFEFF01 without the macro).
  - `a`=0x0ABC, `b`=0, `c`=0x7F -> 0x00007F.
- Handshake: pulse `in_start` at `i`=3 with different operands -> ignored, first result still correct. Start again while `out_valid`=1 -> `out_valid`=0 after the next edge, new result 6 cycles later.
- Reset mid-operation: assert `rst_n`=0 at `i`=2 -> outputs return to reset values asynchronously. After release, `a`=7, `b`=9, `c`=1 -> 0x000040.
- Round-trip: 1000 random dividends and nonzero divisors through the divider; feed quotient, divisor and remainder here -> `out_data` equals the zero-extended dividend in every case (macro defined).
